// File: rtl/apb_sfr_bank_if.sv
// apbif: APB bus bundle with master and slave modports.
interface apbif #(parameter int PAW = 12, parameter int DW = 32);
  logic psel, penable, pwrite, pready, pslverr;
  logic [PAW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic [DW/8-1:0] pstrb;
  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb, input prdata, pready, pslverr);
  modport slave (input psel, penable, pwrite, paddr, pwdata, pstrb, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_sfr_bank.sv
// apb_sfr_bank: APB bank of CR/SR/FR/AR registers; APB_SFR_BANK_SLVERR_EN enables pslverr.
module apb_sfr_bank #(
  parameter logic [31:0] A = 'h0,
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int NREG = 8,
  parameter logic [2*NREG-1:0] MODE = '0,
  parameter logic [NREG*DW-1:0] IV = '0,
  parameter logic [31:0] ARKEY = 32'h5a,
  parameter int RDWS = 0,
  parameter logic [NREG-1:0] FRIRQ = '1
) (
  input logic pclk,
  input logic reset,
  apbif.slave apbs,
  input logic sfrlock,
  input logic [NREG*DW-1:0] sr,
  input logic [NREG*DW-1:0] fr_set,
  output logic [NREG*DW-1:0] cr,
  output logic [NREG-1:0] ar_pulse,
  output logic irq
);
  localparam int NB = DW/8;
  logic [NREG-1:0][DW-1:0] cr_q, cr_d, fr_q, fr_d;
  logic [NREG-1:0] ar_q, ar_d, sel;
  logic irq_q, irq_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] off;
  logic [DW-1:0] rval, clr;
  logic access, in_win, hit, done, wr_ok;
  always_comb begin
    off = apbs.paddr - AW'(A);
    in_win = 32'(off) < 32'(4*NREG);
    hit = in_win && off[1:0] == 2'b00;
    access = apbs.psel && apbs.penable;
    apbs.pready = reset || apbs.pwrite || !access || wcnt_q == 2'(RDWS);
    done = access && apbs.pready && !reset;
    wr_ok = done && apbs.pwrite && hit && !sfrlock;
    wcnt_d = (!apbs.psel || done) ? 2'd0 : access ? wcnt_q + 2'd1 : wcnt_q;
    sel = '0;
    rval = '0;
    clr = '0;
    cr_d = cr_q;
    fr_d = fr_q;
    ar_d = '0;
    irq_d = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      sel[i] = hit && off == AW'(4*i);
      if (MODE[2*i +: 2] == 2'd0) begin
        rval = sel[i] ? cr_q[i] : rval;
        for (int b = 0; b < NB; b++)
          if (wr_ok && sel[i] && apbs.pstrb[b]) cr_d[i][8*b +: 8] = apbs.pwdata[8*b +: 8];
      end
      if (MODE[2*i +: 2] == 2'd1) rval = sel[i] ? sr[i*DW +: DW] : rval;
      // set wins over a simultaneous write-1-to-clear
      if (MODE[2*i +: 2] == 2'd2) begin
        rval = sel[i] ? fr_q[i] : rval;
        for (int b = 0; b < NB; b++)
          clr[8*b +: 8] = (wr_ok && sel[i] && apbs.pstrb[b]) ? apbs.pwdata[8*b +: 8] : 8'h00;
        fr_d[i] = (fr_q[i] & ~clr) | fr_set[i*DW +: DW];
      end
      if (MODE[2*i +: 2] == 2'd3) ar_d[i] = wr_ok && sel[i] && apbs.pwdata[DW-1:0] == ARKEY[DW-1:0];
      irq_d = irq_d | (FRIRQ[i] && |fr_q[i]);
    end
    apbs.prdata = (done && !apbs.pwrite) ? 32'(rval) : 32'h0;
  end
`ifdef APB_SFR_BANK_SLVERR_EN
  assign apbs.pslverr = done && in_win && (!hit || (apbs.pwrite && sfrlock));
`else
  assign apbs.pslverr = 1'b0;
`endif
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      cr_q <= IV;
      fr_q <= '0;
      ar_q <= '0;
      irq_q <= 1'b0;
      wcnt_q <= 2'd0;
    end else begin
      cr_q <= cr_d;
      fr_q <= fr_d;
      ar_q <= ar_d;
      irq_q <= irq_d;
      wcnt_q <= wcnt_d;
    end
  end
  assign cr = cr_q;
  assign ar_pulse = ar_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_apb_sfr_bank.sv
// tb_apb_sfr_bank: vector table plus corner sequences; reg0 CR, reg1 SR, reg2 FR, reg3 AR.
module tb_apb_sfr_bank;
`ifdef APB_SFR_BANK_SLVERR_EN
  localparam logic E = 1'b1;
`else
  localparam logic E = 1'b0;
`endif
  typedef struct {logic w; logic [11:0] a; logic [31:0] d; logic [3:0] s; logic lk; logic [31:0] er; logic ee; int ew;} vec_t;
  typedef struct {logic [31:0] rd; logic e; int w;} exp_t;
  logic pclk = 0, reset = 1, sfrlock = 0;
  logic [127:0] sr, fr_set, cr;
  logic [3:0] ar_pulse;
  logic irq;
  int total = 0, bad = 0;
  vec_t v[$];
  exp_t sb[$];
  apbif #(.PAW(12), .DW(32)) bus();
  apb_sfr_bank #(.A(32'h100), .AW(12), .DW(32), .NREG(4), .MODE(8'b11_10_01_00),
    .IV(128'h000000ff), .ARKEY(32'h5a), .RDWS(2), .FRIRQ(4'b0100)) dut (
    .pclk(pclk), .reset(reset), .apbs(bus), .sfrlock(sfrlock), .sr(sr), .fr_set(fr_set),
    .cr(cr), .ar_pulse(ar_pulse), .irq(irq));
  always #5 pclk = ~pclk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic er, output int ws);
    @(posedge pclk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d; bus.pstrb = s;
    @(posedge pclk); #1;
    bus.penable = 1;
    ws = 0;
    @(negedge pclk);
    while (!bus.pready && ws < 8) begin
      chk("wait_prdata", bus.prdata, 32'h0);
      ws++;
      @(negedge pclk);
    end
    rd = bus.prdata;
    er = bus.pslverr;
    @(posedge pclk); #1;
    bus.psel = 0; bus.penable = 0;
  endtask
  initial begin
    logic [31:0] rd;
    logic er;
    int ws, cnt;
    exp_t e;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
    sr = '0; sr[63:32] = 32'hdead; fr_set = '0;
    v.push_back('{0, 12'h100, 32'h0, 4'h0, 0, 32'h000000ff, 0, 2});
    v.push_back('{1, 12'h100, 32'h12345678, 4'b0011, 0, 32'h0, 0, 0});
    v.push_back('{0, 12'h100, 32'h0, 4'h0, 0, 32'h00005678, 0, 2});
    v.push_back('{1, 12'h100, 32'haabbccdd, 4'b1100, 0, 32'h0, 0, 0});
    v.push_back('{0, 12'h100, 32'h0, 4'h0, 0, 32'haabb5678, 0, 2});
    v.push_back('{0, 12'h104, 32'h0, 4'h0, 0, 32'h0000dead, 0, 2});
    v.push_back('{1, 12'h104, 32'hffffffff, 4'hf, 0, 32'h0, 0, 0});
    v.push_back('{0, 12'h104, 32'h0, 4'h0, 0, 32'h0000dead, 0, 2});
    v.push_back('{0, 12'h10c, 32'h0, 4'h0, 0, 32'h0, 0, 2});
    v.push_back('{0, 12'h102, 32'h0, 4'h0, 0, 32'h0, E, 2});
    v.push_back('{1, 12'h102, 32'h0, 4'hf, 0, 32'h0, E, 0});
    v.push_back('{1, 12'h200, 32'hffffffff, 4'hf, 0, 32'h0, 0, 0});
    v.push_back('{0, 12'h100, 32'h0, 4'h0, 0, 32'haabb5678, 0, 2});
    v.push_back('{0, 12'h110, 32'h0, 4'h0, 0, 32'h0, 0, 2});
    v.push_back('{1, 12'h100, 32'h0, 4'hf, 1, 32'h0, E, 0});
    v.push_back('{0, 12'h100, 32'h0, 4'h0, 1, 32'haabb5678, 0, 2});
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_pready", 32'(bus.pready), 32'h1);
    chk("rst_prdata", bus.prdata, 32'h0);
    chk("rst_cr0", cr[31:0], 32'h000000ff);
    chk("rst_ar_irq", {27'h0, ar_pulse, irq}, 32'h0);
    reset = 0;
    foreach (v[k]) begin
      sfrlock = v[k].lk;
      sb.push_back('{v[k].er, v[k].ee, v[k].ew});
      xfer(v[k].w, v[k].a, v[k].d, v[k].s, rd, er, ws);
      e = sb.pop_front();
      chk($sformatf("v%0d_rdata", k), rd, e.rd);
      chk($sformatf("v%0d_err", k), 32'(er), 32'(e.e));
      chk($sformatf("v%0d_waits", k), 32'(ws), 32'(e.w));
    end
    sfrlock = 0;
    chk("cr_port", cr[31:0], 32'haabb5678);
    // FR sticky bit, irq, set-beats-clear
    @(posedge pclk); #1 fr_set[67] = 1;
    @(posedge pclk); #1 fr_set[67] = 0;
    @(posedge pclk); #1;
    chk("fr_irq_set", 32'(irq), 32'h1);
    xfer(0, 12'h108, 0, 0, rd, er, ws);
    chk("fr_read_set", rd, 32'h8);
    @(posedge pclk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 12'h108; bus.pwdata = 32'h8; bus.pstrb = 4'hf;
    @(posedge pclk); #1;
    bus.penable = 1; fr_set[67] = 1;
    @(posedge pclk); #1;
    bus.psel = 0; bus.penable = 0; fr_set[67] = 0;
    xfer(0, 12'h108, 0, 0, rd, er, ws);
    chk("fr_set_wins", rd, 32'h8);
    xfer(1, 12'h108, 32'h8, 4'hf, rd, er, ws);
    xfer(0, 12'h108, 0, 0, rd, er, ws);
    chk("fr_cleared", rd, 32'h0);
    chk("fr_irq_clr", 32'(irq), 32'h0);
    // AR pulses
    xfer(1, 12'h10c, 32'h5a, 4'hf, rd, er, ws);
    @(negedge pclk);
    chk("ar_pulse_now", 32'(ar_pulse), 32'h8);
    cnt = 0;
    repeat (4) begin @(negedge pclk); cnt += int'(ar_pulse[3]); end
    chk("ar_pulse_width", 32'(cnt), 32'h0);
    xfer(1, 12'h10c, 32'h5b, 4'hf, rd, er, ws);
    cnt = 0;
    repeat (4) begin @(negedge pclk); cnt += int'(ar_pulse[3]); end
    chk("ar_wrong_key", 32'(cnt), 32'h0);
    sfrlock = 1;
    xfer(1, 12'h10c, 32'h5a, 4'hf, rd, er, ws);
    chk("ar_lock_err", 32'(er), 32'(E));
    cnt = 0;
    repeat (4) begin @(negedge pclk); cnt += int'(ar_pulse[3]); end
    chk("ar_locked", 32'(cnt), 32'h0);
    sfrlock = 0;
    // reset during a read wait state
    @(posedge pclk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = 0; bus.paddr = 12'h104;
    @(posedge pclk); #1;
    bus.penable = 1;
    @(negedge pclk);
    chk("mid_wait", 32'(bus.pready), 32'h0);
    #1 reset = 1;
    #1;
    chk("mid_rst_pready", 32'(bus.pready), 32'h1);
    chk("mid_rst_prdata", bus.prdata, 32'h0);
    chk("mid_rst_cr", cr[31:0], 32'h000000ff);
    @(posedge pclk); #1;
    bus.psel = 0; bus.penable = 0;
    @(posedge pclk); #1 reset = 0;
    xfer(0, 12'h104, 0, 0, rd, er, ws);
    chk("post_rst_data", rd, 32'h0000dead);
    chk("post_rst_waits", 32'(ws), 32'h2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
